// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one synchronous-read, single-port word memory between the
// instruction fetch unit (read only) and the load/store unit. Each requester
// has a valid/ready request channel and a valid/ready response channel.
// Contention is resolved round-robin. Byte addresses are translated to word
// indices relative to BASE, and out-of-range or misaligned accesses return an
// error response without touching the memory. An error response has the same
// one-cycle latency as a legal access.
module mem_port_arbiter #(
    parameter int                ADDR_W = 64,
    parameter int                DATA_W = 32,
    parameter int                MEM_AW = 13,
    parameter logic [ADDR_W-1:0] BASE   = 64'h0000_0000_8000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // Instruction fetch unit
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_req_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [DATA_W-1:0]     ifu_resp_data,
    output logic                  ifu_resp_err,

    // Load/store unit
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    input  logic [DATA_W/8-1:0]   lsu_req_wmask,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_W-1:0]     lsu_resp_data,
    output logic                  lsu_resp_err,

    // Memory macro port
    output logic                  mem_en,
    output logic                  mem_wen,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    // Requester encoding used for grant, owner and last-grant bookkeeping.
    localparam logic GRANT_IFU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

    // Low two bits the offset must have for the byte address itself to be
    // word aligned. Checking the offset instead of the raw address keeps the
    // legality test a function of the offset alone, and stays correct even if
    // BASE is not word aligned.
    localparam logic [1:0] ALIGN_OFF = 2'b00 - BASE[1:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,   // no outstanding access
        ST_RESP = 2'b01,   // response driven from live memory output
        ST_HOLD = 2'b10    // response driven from the hold register
    } state_t;

    // An offset is legal when it lands inside the memory window and the
    // underlying byte address is word aligned.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] off);
        return (off[ADDR_W-1:MEM_AW+2] == '0) && (off[1:0] == ALIGN_OFF);
    endfunction

    // Word index of an in-window offset.
    function automatic logic [MEM_AW-1:0] word_index(input logic [ADDR_W-1:0] off);
        return off[MEM_AW+1:2];
    endfunction

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 last_grant_r;
    logic                 owner_r;
    logic                 err_r;
    logic                 wr_r;
    logic [DATA_W-1:0]    hold_r;

    logic                 grant_s;
    logic                 owner_ready_s;
    logic                 can_accept_s;
    logic                 hs_s;
    logic [ADDR_W-1:0]    sel_addr_s;
    logic [ADDR_W-1:0]    off_s;
    logic                 legal_s;
    logic                 resp_active_s;
    logic [DATA_W-1:0]    resp_data_s;

    // Round-robin grant: a lone requester wins; under contention the one
    // not granted last wins. With nobody asking, point at the next-in-turn.
    always_comb begin
        grant_s = ~last_grant_r;
        if (ifu_req_valid && lsu_req_valid) begin
            grant_s = ~last_grant_r;
        end else if (ifu_req_valid) begin
            grant_s = GRANT_IFU;
        end else if (lsu_req_valid) begin
            grant_s = GRANT_LSU;
        end else begin
            grant_s = ~last_grant_r;
        end
    end

    // Acceptance and request handshake. A new request is only taken when the
    // port is free or the pending response is retired in this same cycle.
    always_comb begin
        owner_ready_s = (owner_r == GRANT_LSU) ? lsu_resp_ready : ifu_resp_ready;
        can_accept_s  = (state_r == ST_IDLE) ||
                        ((state_r == ST_RESP) && owner_ready_s);
        ifu_req_ready = can_accept_s && (grant_s == GRANT_IFU);
        lsu_req_ready = can_accept_s && (grant_s == GRANT_LSU);
        hs_s          = (ifu_req_valid && ifu_req_ready) ||
                        (lsu_req_valid && lsu_req_ready);
    end

    // Address decode of the granted requester.
    always_comb begin
        sel_addr_s = (grant_s == GRANT_LSU) ? lsu_req_addr : ifu_req_addr;
        off_s      = sel_addr_s - BASE;
        legal_s    = addr_legal(off_s);
    end

    // Memory port drive: only a legal handshake touches the memory, and the
    // bus is parked at zero otherwise.
    always_comb begin
        mem_en    = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = {STRB_W{1'b0}};
        if (hs_s && legal_s) begin
            mem_en   = 1'b1;
            mem_addr = word_index(off_s);
            if (grant_s == GRANT_LSU) begin
                mem_wen   = lsu_req_wen;
                mem_wdata = lsu_req_wdata;
                mem_wmask = lsu_req_wmask;
            end else begin
                mem_wen   = 1'b0;
                mem_wdata = '0;
                mem_wmask = {STRB_W{1'b0}};
            end
        end else begin
            mem_en   = 1'b0;
            mem_addr = '0;
        end
    end

    // Response payload: writes and errors return zero; reads come straight
    // from the memory in RESP and from the hold register once stalled.
    always_comb begin
        resp_active_s = (state_r != ST_IDLE);
        case (state_r)
            ST_RESP: resp_data_s = (err_r || wr_r) ? '0 : mem_rdata;
            ST_HOLD: resp_data_s = hold_r;
            default: resp_data_s = '0;
        endcase
    end

    // Response routing: only the owner sees valid, data and err.
    always_comb begin
        ifu_resp_valid = 1'b0;
        ifu_resp_data  = '0;
        ifu_resp_err   = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_resp_data  = '0;
        lsu_resp_err   = 1'b0;
        if (resp_active_s && (owner_r == GRANT_IFU)) begin
            ifu_resp_valid = 1'b1;
            ifu_resp_data  = resp_data_s;
            ifu_resp_err   = err_r;
        end else if (resp_active_s && (owner_r == GRANT_LSU)) begin
            lsu_resp_valid = 1'b1;
            lsu_resp_data  = resp_data_s;
            lsu_resp_err   = err_r;
        end else begin
            ifu_resp_valid = 1'b0;
            lsu_resp_valid = 1'b0;
        end
    end

    // Next-state logic for the outstanding-access tracker.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (!owner_ready_s) begin
                    state_nxt_s = ST_HOLD;
                end else if (hs_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (owner_ready_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register; reset drops any outstanding response at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Per-access bookkeeping captured on each accepted request. Last grant
    // resets to LSU so the IFU wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= GRANT_LSU;
            owner_r      <= GRANT_IFU;
            err_r        <= 1'b0;
            wr_r         <= 1'b0;
        end else if (hs_s) begin
            last_grant_r <= grant_s;
            owner_r      <= grant_s;
            err_r        <= ~legal_s;
            wr_r         <= (grant_s == GRANT_LSU) && lsu_req_wen;
        end
    end

    // Hold register: freezes the response on the edge it first stalls, so
    // the memory output is free to change afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r <= '0;
        end else if ((state_r == ST_RESP) && !owner_ready_s) begin
            hold_r <= resp_data_s;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a behavioural synchronous-read
// word memory behind the port.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 32;
    localparam int MEM_AW = 13;

    logic                 clk;
    logic                 rst_n;
    logic                 ifu_req_valid;
    logic                 ifu_req_ready;
    logic [ADDR_W-1:0]    ifu_req_addr;
    logic                 ifu_resp_valid;
    logic                 ifu_resp_ready;
    logic [DATA_W-1:0]    ifu_resp_data;
    logic                 ifu_resp_err;
    logic                 lsu_req_valid;
    logic                 lsu_req_ready;
    logic [ADDR_W-1:0]    lsu_req_addr;
    logic                 lsu_req_wen;
    logic [DATA_W-1:0]    lsu_req_wdata;
    logic [DATA_W/8-1:0]  lsu_req_wmask;
    logic                 lsu_resp_valid;
    logic                 lsu_resp_ready;
    logic [DATA_W-1:0]    lsu_resp_data;
    logic                 lsu_resp_err;
    logic                 mem_en;
    logic                 mem_wen;
    logic [MEM_AW-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W/8-1:0]  mem_wmask;
    logic [DATA_W-1:0]    mem_rdata;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [DATA_W-1:0] mem_model [0:(1<<MEM_AW)-1];
    bit preloaded = 1'b0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW),
        .BASE(64'h0000_0000_8000_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word i holds 0xA000_0000|i, except word 1 (0x13) and
    // word 4 (all ones). Read data appears one cycle after mem_en.
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < (1 << MEM_AW); i++) begin
                mem_model[i] <= 32'hA000_0000 | i;
            end
            mem_model[1] <= 32'h0000_0013;
            mem_model[4] <= 32'hFFFF_FFFF;
            mem_rdata    <= 32'h0000_0000;
            preloaded    <= 1'b1;
        end else if (mem_en) begin
            if (mem_wen) begin
                for (int b = 0; b < DATA_W/8; b++) begin
                    if (mem_wmask[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem_model[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ifu_req_valid = 1'b0; ifu_req_addr = '0; ifu_resp_ready = 1'b1;
        lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
        lsu_req_wdata = '0; lsu_req_wmask = '0; lsu_resp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ifu_vld",  ifu_resp_valid, 64'd0);
        chk("rst_lsu_vld",  lsu_resp_valid, 64'd0);
        chk("rst_ifu_data", ifu_resp_data,  64'd0);
        chk("rst_lsu_err",  lsu_resp_err,   64'd0);
        chk("rst_mem_en",   mem_en,         64'd0);
        @(negedge clk) rst_n = 1'b1;

        // Contention: IFU word 8, LSU word 16, four grants alternating
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0020;
        lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_0040; lsu_req_wen = 1'b0;
        #1;
        chk("cont0_ifu_rdy", ifu_req_ready, 64'd1);
        chk("cont0_lsu_rdy", lsu_req_ready, 64'd0);
        chk("cont0_addr",    mem_addr,      64'd8);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if ((k % 2) == 0) begin
                chk("cont_ifu_vld",  ifu_resp_valid, 64'd1);
                chk("cont_ifu_data", ifu_resp_data,  64'hA000_0008);
                chk("cont_lsu_idle", lsu_resp_valid, 64'd0);
                chk("cont_lsu_rdy",  lsu_req_ready,  64'd1);
                chk("cont_addr16",   mem_addr,       64'd16);
            end else begin
                chk("cont_lsu_vld",  lsu_resp_valid, 64'd1);
                chk("cont_lsu_data", lsu_resp_data,  64'hA000_0010);
                chk("cont_ifu_idle", ifu_resp_valid, 64'd0);
                chk("cont_ifu_rdy",  ifu_req_ready,  64'd1);
                chk("cont_addr8",    mem_addr,       64'd8);
            end
        end
        @(negedge clk); ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        @(posedge clk); #1;
        chk("cont_end_ifu", ifu_resp_valid, 64'd0);
        chk("cont_end_lsu", lsu_resp_valid, 64'd0);

        // Single fetch of word 1
        @(negedge clk); ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0004;
        #1;
        chk("fetch_rdy",  ifu_req_ready, 64'd1);
        chk("fetch_en",   mem_en,        64'd1);
        chk("fetch_addr", mem_addr,      64'd1);
        @(posedge clk); #1;
        chk("fetch_vld",  ifu_resp_valid, 64'd1);
        chk("fetch_data", ifu_resp_data,  64'h0000_0013);
        chk("fetch_err",  ifu_resp_err,   64'd0);
        chk("fetch_lsu",  lsu_resp_valid, 64'd0);
        chk("fetch_lsu_data", lsu_resp_data, 64'd0);

        // Store 0xDEADBEEF mask 0011 to word 4, then load it back
        @(negedge clk);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 64'h8000_0010;
        lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'b0011;
        #1;
        chk("st_rdy",   lsu_req_ready, 64'd1);
        chk("st_en",    mem_en,        64'd1);
        chk("st_wen",   mem_wen,       64'd1);
        chk("st_addr",  mem_addr,      64'd4);
        chk("st_mask",  mem_wmask,     64'h3);
        chk("st_wdata", mem_wdata,     64'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("st_ack_vld",  lsu_resp_valid, 64'd1);
        chk("st_ack_data", lsu_resp_data,  64'd0);
        chk("st_ack_err",  lsu_resp_err,   64'd0);
        @(negedge clk);
        lsu_req_wen = 1'b0; lsu_req_wdata = '0; lsu_req_wmask = '0;
        #1;
        chk("ld_en",   mem_en,   64'd1);
        chk("ld_wen",  mem_wen,  64'd0);
        chk("ld_addr", mem_addr, 64'd4);
        @(posedge clk); #1;
        chk("ld_vld",  lsu_resp_valid, 64'd1);
        chk("ld_data", lsu_resp_data,  64'hFFFF_BEEF);

        // Backpressure on the load response for three cycles
        @(negedge clk);
        lsu_resp_ready = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0004;
        lsu_req_addr = 64'h8000_0040;
        #1;
        chk("bp_ifu_rdy0", ifu_req_ready, 64'd0);
        chk("bp_lsu_rdy0", lsu_req_ready, 64'd0);
        chk("bp_en0",      mem_en,        64'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_vld",     lsu_resp_valid, 64'd1);
            chk("bp_data",    lsu_resp_data,  64'hFFFF_BEEF);
            chk("bp_ifu_rdy", ifu_req_ready,  64'd0);
            chk("bp_lsu_rdy", lsu_req_ready,  64'd0);
            chk("bp_en",      mem_en,         64'd0);
        end
        @(negedge clk);
        lsu_resp_ready = 1'b1; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        #1;
        chk("bp_rel_vld",  lsu_resp_valid, 64'd1);
        chk("bp_rel_data", lsu_resp_data,  64'hFFFF_BEEF);
        chk("bp_rel_rdy",  lsu_req_ready,  64'd0);
        @(posedge clk); #1;
        chk("bp_done_vld",  lsu_resp_valid, 64'd0);
        chk("bp_done_idle", ifu_req_ready | lsu_req_ready, 64'd1);

        // Address errors: one past the window, then misaligned
        @(negedge clk); ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_8000;
        #1;
        chk("oor_rdy", ifu_req_ready, 64'd1);
        chk("oor_en",  mem_en,        64'd0);
        @(posedge clk); #1;
        chk("oor_vld",  ifu_resp_valid, 64'd1);
        chk("oor_err",  ifu_resp_err,   64'd1);
        chk("oor_data", ifu_resp_data,  64'd0);
        @(negedge clk); ifu_req_addr = 64'h8000_0002;
        #1;
        chk("mis_rdy", ifu_req_ready, 64'd1);
        chk("mis_en",  mem_en,        64'd0);
        @(posedge clk); #1;
        chk("mis_vld",  ifu_resp_valid, 64'd1);
        chk("mis_err",  ifu_resp_err,   64'd1);
        chk("mis_data", ifu_resp_data,  64'd0);
        @(negedge clk); ifu_req_valid = 1'b0;
        @(posedge clk); #1;
        chk("err_end_vld", ifu_resp_valid, 64'd0);
        chk("err_end_err", ifu_resp_err,   64'd0);

        // Reset while the IFU response is held
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0004; ifu_resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk); ifu_req_valid = 1'b0;
        @(posedge clk); #1;
        chk("hold_vld",  ifu_resp_valid, 64'd1);
        chk("hold_data", ifu_resp_data,  64'h0000_0013);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld",  ifu_resp_valid, 64'd0);
        chk("arst_data", ifu_resp_data,  64'd0);
        @(negedge clk); rst_n = 1'b1; ifu_resp_ready = 1'b1;
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0004;
        lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_0040;
        #1;
        chk("post_rst_ifu_rdy", ifu_req_ready, 64'd1);
        chk("post_rst_lsu_rdy", lsu_req_ready, 64'd0);
        @(posedge clk); #1;
        chk("post_rst_vld",  ifu_resp_valid, 64'd1);
        chk("post_rst_data", ifu_resp_data,  64'h0000_0013);
        @(negedge clk); ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("final_ifu", ifu_resp_valid, 64'd0);
        chk("final_lsu", lsu_resp_valid, 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
